memory_dp_be: RTL and testbench
===============================

Name: memory_dp_be

Overview:
Next-generation on-chip memory: simple dual-port RAM with one write port and one read port, both on the same clock. Adds per-byte write enables, a registered read path with a valid flag, a selectable read-during-write policy, optional output pipelining, and a self-clearing init sequencer that zeroes the array after reset. Drop-in storage for buffers, lookup tables and descriptor rings throughout the design.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
ADDR_WIDTH, 10, address width; depth = 2**ADDR_WIDTH.
BYTE_WIDTH, 8, bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
RDW_MODE, 0, same-address read-during-write policy: 0 = old data, 1 = new data (write-first).
OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write request
wr_addr  in  ADDR_WIDTH  write address
wr_be  in  NUM_BYTES  per-lane write enable; lane i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH]
wr_data  in  DATA_WIDTH  write data
rd_en  in  1  read request
rd_addr  in  ADDR_WIDTH  read address
rd_valid  out  1  rd_data holds the result of a read issued 1 (OUT_REG=0) or 2 (OUT_REG=1) cycles earlier
rd_data  out  DATA_WIDTH  read data; holds last value when rd_valid=0
init_done  out  1  high once the post-reset clear has finished; ports are live only while high

Behaviour:
- Reset (rst_n=0, asynchronous): rd_valid=0, rd_data=0, init_done=0, clear counter=0, pipeline stages cleared, FSM to INIT. Array contents are not reset asynchronously.
- FSM states: INIT, READY. INIT writes zero to address clr_cnt each cycle and increments clr_cnt. After writing the last address (2**ADDR_WIDTH-1), go to READY and set init_done=1 on the next edge. INIT lasts exactly 2**ADDR_WIDTH cycles. READY is terminal until reset.
- During INIT, wr_en and rd_en are ignored: no array update and rd_valid stays 0.
- Write (READY, wr_en=1): for each lane i with wr_be[i]=1, that byte of mem[wr_addr] takes wr_data at the edge. Lanes with wr_be[i]=0 are unchanged. wr_be=0 with wr_en=1 is a legal no-op.
- Read (READY, rd_en=1): rd_data = mem[rd_addr] and rd_valid=1 after the configured latency. With rd_en=0 the valid pulse for that slot is 0 and rd_data keeps its previous value.
- Back-to-back reads every cycle give one result per cycle. No stalls and no backpressure.
- Read-during-write, same address, same cycle:
  - RDW_MODE=0: result is the pre-write word.
  - RDW_MODE=1: enabled lanes return wr_data bytes; disabled lanes return the stored bytes.
- Different addresses in the same cycle are independent.
- Read at cycle N+1 of an address written at cycle N returns the new data in both modes.
- Reset mid-operation: in-flight reads are discarded (rd_valid=0) and INIT restarts from address 0.
- Elaboration-time check: fatal error if DATA_WIDTH % BYTE_WIDTH != 0 or if RDW_MODE/OUT_REG is not in {0,1}.

Decomposition:
- Package memory_pkg holds:
  - enum init_state_e {INIT, READY}
  - enum rdw_mode_e {RDW_OLD=0, RDW_NEW=1}
  - function num_bytes(data_w, byte_w)
- One natural sub-module, memory_init_seq: the INIT/READY FSM plus clear counter. It outputs init_done, clr_we and clr_addr. The top level muxes the clear write into the write port.
- Array, byte-lane merge, RDW bypass and output pipeline stay in memory_dp_be.

Test Plan:
- Reset release, ADDR_WIDTH=4 -> init_done rises exactly 16 cycles after rst_n deasserts; read every address -> all return 0x00000000.
- Write 0xDEADBEEF to addr 5 with be=4'b1111, then write 0x11223344 to addr 5 with be=4'b0101; read addr 5 -> 0xDE22BE44 with rd_valid one cycle after rd_en (OUT_REG=0), two cycles after (OUT_REG=1).
- Addr 7 holds 0xAAAAAAAA; same cycle write 0x55555555 be=4'b0011 and read addr 7 -> RDW_MODE=0 returns 0xAAAAAAAA, RDW_MODE=1 returns 0xAAAA5555; next-cycle read returns 0xAAAA5555 in both.
- Streaming reads of addr 0..15 on consecutive cycles after filling mem[i]=i -> rd_valid high 16 consecutive cycles, rd_data = 0..15 in order; rd_en gap of one cycle -> single rd_valid=0 bubble, rd_data held.
- wr_en/rd_en asserted during INIT (cycle 3, addr 2, data 0xFFFFFFFF) -> rd_valid stays 0; after init_done, addr 2 reads 0.
- Assert rst_n=0 mid-stream with reads in flight -> rd_valid, rd_data and init_done go to 0 immediately (asynchronous); after release, a full INIT re-runs and earlier data reads back as 0.

Source files
------------

// File: rtl/memory_pkg.sv
// -----------------------------------------------------------------------------
// memory_pkg
// Shared types and helpers for the memory_dp_be storage block.
//   init_state_e : state of the post-reset clear sequencer
//   rdw_mode_e   : same-address read-during-write policy
//   num_bytes()  : number of write-enable lanes for a given word/lane width
// -----------------------------------------------------------------------------
package memory_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } init_state_e;

    typedef enum logic {
        RDW_OLD = 1'b0,
        RDW_NEW = 1'b1
    } rdw_mode_e;

    function automatic int num_bytes(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

endpackage

// File: rtl/memory_dp_be_if.sv
// -----------------------------------------------------------------------------
// memory_dp_be_if
// Bundles the write port, read port and status of memory_dp_be.
//   write : wr_en, wr_addr, wr_be, wr_data
//   read  : rd_en, rd_addr  ->  rd_valid, rd_data
//   status: init_done, init_state (clear-sequencer state, for debug/checkers)
//
// Handshake: there is no ready/backpressure on either port. wr_en and rd_en
// are accepted on every rising edge while init_done=1 and ignored otherwise.
// rd_valid is a single-cycle qualifier: rd_data is meaningful only in a cycle
// where rd_valid=1, and it holds its last value while rd_valid=0.
//
// Modports: master drives requests (bench / client), slave is the memory.
// -----------------------------------------------------------------------------
interface memory_dp_be_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int BYTE_WIDTH = 8
);
    localparam int NUM_BYTES = memory_pkg::num_bytes(DATA_WIDTH, BYTE_WIDTH);

    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [NUM_BYTES-1:0]    wr_be;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    rd_valid;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    init_done;
    memory_pkg::init_state_e init_state;

    modport master (
        output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
        input  rd_valid, rd_data, init_done, init_state
    );

    modport slave (
        input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
        output rd_valid, rd_data, init_done, init_state
    );

endinterface

// File: rtl/memory_init_seq.sv
// -----------------------------------------------------------------------------
// memory_init_seq
// Post-reset clear sequencer. In INIT it requests a zero write to clr_addr on
// every cycle, walking 0 .. 2**ADDR_WIDTH-1, then moves to READY and stays
// there until the next reset.
//   clk, rst_n : clock, asynchronous active-low reset
//   init_done  : high in READY (memory ports live)
//   clr_we     : clear write request (high throughout INIT)
//   clr_addr   : address being cleared this cycle
//   state_o    : current FSM state, exposed for debug
// -----------------------------------------------------------------------------
module memory_init_seq
    import memory_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_done,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output init_state_e           state_o
);

    init_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= INIT;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        case (state_q)
            INIT: begin
                clr_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                // The last address is cleared in this cycle; the counter
                // wraps to 0 so a later reset restarts cleanly.
                if (clr_cnt_q == '1) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
        endcase
    end

    assign clr_addr  = clr_cnt_q;
    assign init_done = (state_q == READY);
    assign state_o   = state_q;

endmodule

// File: rtl/memory_dp_be.sv
// -----------------------------------------------------------------------------
// memory_dp_be
// Simple dual-port RAM (one write port, one read port, single clock) with
// per-byte write enables, registered read with valid flag, selectable
// same-address read-during-write policy, optional extra output register and
// a post-reset clear of the whole array.
//   clk   : clock, all logic on rising edge
//   rst_n : asynchronous active-low reset (array contents are not reset)
//   bus   : memory_dp_be_if.slave (write port, read port, status)
// Read latency is 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1).
// -----------------------------------------------------------------------------
module memory_dp_be
    import memory_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int BYTE_WIDTH = 8,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    memory_dp_be_if.slave  bus
);

    localparam int        NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH);
    localparam int        DEPTH     = 2 ** ADDR_WIDTH;
    localparam rdw_mode_e RDW       = (RDW_MODE == 1) ? RDW_NEW : RDW_OLD;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $fatal(1, "memory_dp_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_bad_rdw
        $fatal(1, "memory_dp_be: RDW_MODE must be 0 or 1");
    end
    if (OUT_REG != 0 && OUT_REG != 1) begin : g_bad_out_reg
        $fatal(1, "memory_dp_be: OUT_REG must be 0 or 1");
    end

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    logic                  init_done;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    init_state_e           init_state;

    memory_init_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_done (init_done),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .state_o   (init_state)
    );

    assign bus.init_done  = init_done;
    assign bus.init_state = init_state;

    // User requests only take effect once the clear has finished.
    logic wr_fire;
    logic rd_fire;

    assign wr_fire = bus.wr_en & init_done;
    assign rd_fire = bus.rd_en & init_done;

    // ------------------------------------------------------------------
    // Write port mux: the clear sequencer owns the port during INIT.
    // ------------------------------------------------------------------
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [NUM_BYTES-1:0]  mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;

    always_comb begin
        mem_we    = wr_fire;
        mem_addr  = bus.wr_addr;
        mem_be    = bus.wr_be;
        mem_wdata = bus.wr_data;
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_addr  = clr_addr;
            mem_be    = '1;
            mem_wdata = '0;
        end
    end

    // Storage array: no reset, written lane by lane.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (mem_be[i]) begin
                    mem_q[mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                        mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read word with read-during-write bypass. The array is sampled before
    // this edge's write lands, so without the bypass the old word is read.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rd_word;

    always_comb begin
        rd_word = mem_q[bus.rd_addr];
        if (RDW == RDW_NEW && wr_fire && (bus.wr_addr == bus.rd_addr)) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (bus.wr_be[i]) begin
                    rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read stage 1 (latency 1). Data only loads on a read so it holds
    // across idle cycles.
    // ------------------------------------------------------------------
    logic                  rd_valid1_q, rd_valid1_d;
    logic [DATA_WIDTH-1:0] rd_data1_q,  rd_data1_d;

    always_comb begin
        rd_valid1_d = rd_fire;
        rd_data1_d  = rd_fire ? rd_word : rd_data1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid1_q <= 1'b0;
            rd_data1_q  <= '0;
        end else begin
            rd_valid1_q <= rd_valid1_d;
            rd_data1_q  <= rd_data1_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional output register (latency 2).
    // ------------------------------------------------------------------
    if (OUT_REG == 1) begin : g_out_reg
        logic                  rd_valid2_q, rd_valid2_d;
        logic [DATA_WIDTH-1:0] rd_data2_q,  rd_data2_d;

        always_comb begin
            rd_valid2_d = rd_valid1_q;
            rd_data2_d  = rd_valid1_q ? rd_data1_q : rd_data2_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_valid2_q <= 1'b0;
                rd_data2_q  <= '0;
            end else begin
                rd_valid2_q <= rd_valid2_d;
                rd_data2_q  <= rd_data2_d;
            end
        end

        assign bus.rd_valid = rd_valid2_q;
        assign bus.rd_data  = rd_data2_q;
    end else begin : g_no_out_reg
        assign bus.rd_valid = rd_valid1_q;
        assign bus.rd_data  = rd_data1_q;
    end

endmodule

// File: tb/tb_memory_dp_be.sv
// -----------------------------------------------------------------------------
// tb_memory_dp_be
// Two instances share one stimulus stream:
//   u_old_lat1 : RDW_MODE=0 (old data), OUT_REG=0 (latency 1)
//   u_new_lat2 : RDW_MODE=1 (new data), OUT_REG=1 (latency 2)
// ADDR_WIDTH=4 so the clear takes 16 cycles. Inputs are driven and outputs
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_memory_dp_be;
    import memory_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int BW    = 8;
    localparam int NB    = DW / BW;
    localparam int DEPTH = 2 ** AW;

    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    // Expected array contents, set by hand in each scenario.
    logic [DW-1:0] exp_mem [DEPTH];

    memory_dp_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) bus0 ();
    memory_dp_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) bus1 ();

    assign bus1.wr_en   = bus0.wr_en;
    assign bus1.wr_addr = bus0.wr_addr;
    assign bus1.wr_be   = bus0.wr_be;
    assign bus1.wr_data = bus0.wr_data;
    assign bus1.rd_en   = bus0.rd_en;
    assign bus1.rd_addr = bus0.rd_addr;

    memory_dp_be #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .BYTE_WIDTH (BW),
        .RDW_MODE   (0),  .OUT_REG    (0)
    ) u_old_lat1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    memory_dp_be #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .BYTE_WIDTH (BW),
        .RDW_MODE   (1),  .OUT_REG    (1)
    ) u_new_lat2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // ------------------------------------------------------------------
    // Clock / watchdog
    // ------------------------------------------------------------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [NB-1:0] be);
        @(negedge clk);
        bus0.wr_en   = 1'b1;
        bus0.wr_addr = a;
        bus0.wr_data = d;
        bus0.wr_be   = be;
        @(negedge clk);
        bus0.wr_en   = 1'b0;
    endtask

    task automatic clear_expected();
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    endtask

    // Release reset on a falling edge and count rising edges until init_done.
    task automatic release_and_wait(input string tag);
        int cycles;
        cycles = 0;
        @(negedge clk);
        rst_n = 1'b1;
        while (bus0.init_done !== 1'b1 && cycles < 64) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checks++; if (cycles != 16) begin failures++; $display("FAIL %s_init_cycles: got %0d expected 16", tag, cycles); end
        checks++; if (bus1.init_done !== 1'b1) begin failures++; $display("FAIL %s_u1_init_done: got %0b expected 1", tag, bus1.init_done); end
    endtask

    // Stream reads of every address on consecutive cycles and check both
    // instances against exp_mem at their own latency.
    task automatic test_read_all(input string tag);
        for (int k = 0; k <= DEPTH + 1; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= DEPTH) begin
                checks++;
                if (bus0.rd_valid !== 1'b1 || bus0.rd_data !== exp_mem[k-1]) begin
                    failures++;
                    $display("FAIL %s_u0_addr%0d: got valid=%0b data=%h expected valid=1 data=%h",
                             tag, k - 1, bus0.rd_valid, bus0.rd_data, exp_mem[k-1]);
                end
            end
            if (k >= 2) begin
                checks++;
                if (bus1.rd_valid !== 1'b1 || bus1.rd_data !== exp_mem[k-2]) begin
                    failures++;
                    $display("FAIL %s_u1_addr%0d: got valid=%0b data=%h expected valid=1 data=%h",
                             tag, k - 2, bus1.rd_valid, bus1.rd_data, exp_mem[k-2]);
                end
            end
            if (k < DEPTH) begin
                bus0.rd_en   = 1'b1;
                bus0.rd_addr = AW'(k);
            end else begin
                bus0.rd_en   = 1'b0;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n        = 1'b1;
        bus0.wr_en   = 1'b0;
        bus0.wr_addr = '0;
        bus0.wr_be   = '0;
        bus0.wr_data = '0;
        bus0.rd_en   = 1'b0;
        bus0.rd_addr = '0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus0.rd_valid !== 1'b0) begin failures++; $display("FAIL rst_u0_valid: got %0b expected 0", bus0.rd_valid); end
        checks++; if (bus0.rd_data !== 32'h0) begin failures++; $display("FAIL rst_u0_data: got %h expected 00000000", bus0.rd_data); end
        checks++; if (bus0.init_done !== 1'b0) begin failures++; $display("FAIL rst_u0_init_done: got %0b expected 0", bus0.init_done); end
        checks++; if (bus0.init_state !== INIT) begin failures++; $display("FAIL rst_u0_state: got %0d expected INIT", bus0.init_state); end
        checks++; if (bus1.rd_valid !== 1'b0) begin failures++; $display("FAIL rst_u1_valid: got %0b expected 0", bus1.rd_valid); end
        checks++; if (bus1.rd_data !== 32'h0) begin failures++; $display("FAIL rst_u1_data: got %h expected 00000000", bus1.rd_data); end
        checks++; if (bus1.init_done !== 1'b0) begin failures++; $display("FAIL rst_u1_init_done: got %0b expected 0", bus1.init_done); end
        release_and_wait("rst");
        checks++; if (bus0.init_state !== READY) begin failures++; $display("FAIL rst_u0_ready: got %0d expected READY", bus0.init_state); end
        clear_expected();
        test_read_all("rst_zero");
    endtask

    task automatic test_byte_enable();
        write_word(4'd5, 32'hDEADBEEF, 4'b1111);
        write_word(4'd5, 32'h11223344, 4'b0101);
        bus0.rd_en   = 1'b1;
        bus0.rd_addr = 4'd5;
        @(negedge clk);
        bus0.rd_en = 1'b0;
        checks++; if (bus0.rd_valid !== 1'b1 || bus0.rd_data !== 32'hDE22BE44) begin failures++; $display("FAIL be_u0_lat1: got valid=%0b data=%h expected valid=1 data=de22be44", bus0.rd_valid, bus0.rd_data); end
        checks++; if (bus1.rd_valid !== 1'b0) begin failures++; $display("FAIL be_u1_early: got valid=%0b expected 0", bus1.rd_valid); end
        @(negedge clk);
        checks++; if (bus0.rd_valid !== 1'b0 || bus0.rd_data !== 32'hDE22BE44) begin failures++; $display("FAIL be_u0_hold: got valid=%0b data=%h expected valid=0 data=de22be44", bus0.rd_valid, bus0.rd_data); end
        checks++; if (bus1.rd_valid !== 1'b1 || bus1.rd_data !== 32'hDE22BE44) begin failures++; $display("FAIL be_u1_lat2: got valid=%0b data=%h expected valid=1 data=de22be44", bus1.rd_valid, bus1.rd_data); end
        @(negedge clk);
        checks++; if (bus1.rd_valid !== 1'b0 || bus1.rd_data !== 32'hDE22BE44) begin failures++; $display("FAIL be_u1_hold: got valid=%0b data=%h expected valid=0 data=de22be44", bus1.rd_valid, bus1.rd_data); end
    endtask

    task automatic test_rdw();
        write_word(4'd7, 32'hAAAAAAAA, 4'b1111);
        bus0.wr_en   = 1'b1;
        bus0.wr_addr = 4'd7;
        bus0.wr_data = 32'h55555555;
        bus0.wr_be   = 4'b0011;
        bus0.rd_en   = 1'b1;
        bus0.rd_addr = 4'd7;
        @(negedge clk);
        checks++; if (bus0.rd_valid !== 1'b1 || bus0.rd_data !== 32'hAAAAAAAA) begin failures++; $display("FAIL rdw_u0_old: got valid=%0b data=%h expected valid=1 data=aaaaaaaa", bus0.rd_valid, bus0.rd_data); end
        bus0.wr_en = 1'b0;
        @(negedge clk);
        bus0.rd_en = 1'b0;
        checks++; if (bus0.rd_valid !== 1'b1 || bus0.rd_data !== 32'hAAAA5555) begin failures++; $display("FAIL rdw_u0_next: got valid=%0b data=%h expected valid=1 data=aaaa5555", bus0.rd_valid, bus0.rd_data); end
        checks++; if (bus1.rd_valid !== 1'b1 || bus1.rd_data !== 32'hAAAA5555) begin failures++; $display("FAIL rdw_u1_new: got valid=%0b data=%h expected valid=1 data=aaaa5555", bus1.rd_valid, bus1.rd_data); end
        @(negedge clk);
        checks++; if (bus1.rd_valid !== 1'b1 || bus1.rd_data !== 32'hAAAA5555) begin failures++; $display("FAIL rdw_u1_next: got valid=%0b data=%h expected valid=1 data=aaaa5555", bus1.rd_valid, bus1.rd_data); end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            bus0.wr_en   = 1'b1;
            bus0.wr_addr = AW'(i);
            bus0.wr_data = DW'(i);
            bus0.wr_be   = 4'b1111;
            exp_mem[i]   = DW'(i);
        end
        @(negedge clk);
        bus0.wr_en = 1'b0;
        test_read_all("stream");
        // One-cycle gap between two reads.
        @(negedge clk);
        bus0.rd_en   = 1'b1;
        bus0.rd_addr = 4'd3;
        @(negedge clk);
        bus0.rd_en   = 1'b0;
        checks++; if (bus0.rd_valid !== 1'b1 || bus0.rd_data !== 32'd3) begin failures++; $display("FAIL gap_u0_first: got valid=%0b data=%h expected valid=1 data=3", bus0.rd_valid, bus0.rd_data); end
        @(negedge clk);
        bus0.rd_en   = 1'b1;
        bus0.rd_addr = 4'd9;
        checks++; if (bus0.rd_valid !== 1'b0 || bus0.rd_data !== 32'd3) begin failures++; $display("FAIL gap_u0_bubble: got valid=%0b data=%h expected valid=0 data=3", bus0.rd_valid, bus0.rd_data); end
        checks++; if (bus1.rd_valid !== 1'b1 || bus1.rd_data !== 32'd3) begin failures++; $display("FAIL gap_u1_first: got valid=%0b data=%h expected valid=1 data=3", bus1.rd_valid, bus1.rd_data); end
        @(negedge clk);
        bus0.rd_en = 1'b0;
        checks++; if (bus0.rd_valid !== 1'b1 || bus0.rd_data !== 32'd9) begin failures++; $display("FAIL gap_u0_second: got valid=%0b data=%h expected valid=1 data=9", bus0.rd_valid, bus0.rd_data); end
        checks++; if (bus1.rd_valid !== 1'b0 || bus1.rd_data !== 32'd3) begin failures++; $display("FAIL gap_u1_bubble: got valid=%0b data=%h expected valid=0 data=3", bus1.rd_valid, bus1.rd_data); end
        @(negedge clk);
        checks++; if (bus1.rd_valid !== 1'b1 || bus1.rd_data !== 32'd9) begin failures++; $display("FAIL gap_u1_second: got valid=%0b data=%h expected valid=1 data=9", bus1.rd_valid, bus1.rd_data); end
    endtask

    task automatic test_init_ignore();
        logic exp_done;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            @(negedge clk);
            exp_done = (k == DEPTH);
            checks++; if (bus0.rd_valid !== 1'b0 || bus1.rd_valid !== 1'b0) begin failures++; $display("FAIL init_valid_c%0d: got u0=%0b u1=%0b expected 0", k, bus0.rd_valid, bus1.rd_valid); end
            checks++; if (bus0.init_done !== exp_done) begin failures++; $display("FAIL init_done_c%0d: got %0b expected %0b", k, bus0.init_done, exp_done); end
            if (k == 3) begin
                bus0.wr_en   = 1'b1;
                bus0.wr_addr = 4'd2;
                bus0.wr_data = 32'hFFFFFFFF;
                bus0.wr_be   = 4'b1111;
                bus0.rd_en   = 1'b1;
                bus0.rd_addr = 4'd2;
            end else if (k == 4) begin
                bus0.wr_en = 1'b0;
                bus0.rd_en = 1'b0;
            end
        end
        clear_expected();
        test_read_all("init_ignore");
    endtask

    task automatic test_reset_mid();
        write_word(4'd4, 32'h12345678, 4'b1111);
        bus0.rd_en   = 1'b1;
        bus0.rd_addr = 4'd4;
        @(negedge clk);
        checks++; if (bus0.rd_valid !== 1'b1 || bus0.rd_data !== 32'h12345678) begin failures++; $display("FAIL mid_u0_pre: got valid=%0b data=%h expected valid=1 data=12345678", bus0.rd_valid, bus0.rd_data); end
        #2;
        rst_n      = 1'b0;
        bus0.rd_en = 1'b0;
        #1;
        checks++; if (bus0.rd_valid !== 1'b0 || bus0.rd_data !== 32'h0) begin failures++; $display("FAIL mid_u0_async: got valid=%0b data=%h expected valid=0 data=0", bus0.rd_valid, bus0.rd_data); end
        checks++; if (bus1.rd_valid !== 1'b0 || bus1.rd_data !== 32'h0) begin failures++; $display("FAIL mid_u1_async: got valid=%0b data=%h expected valid=0 data=0", bus1.rd_valid, bus1.rd_data); end
        checks++; if (bus0.init_done !== 1'b0 || bus1.init_done !== 1'b0) begin failures++; $display("FAIL mid_init_done: got u0=%0b u1=%0b expected 0", bus0.init_done, bus1.init_done); end
        checks++; if (bus0.init_state !== INIT) begin failures++; $display("FAIL mid_state: got %0d expected INIT", bus0.init_state); end
        release_and_wait("mid");
        clear_expected();
        test_read_all("mid_zero");
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_byte_enable();
        test_rdw();
        test_streaming();
        test_init_ignore();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
